acker_pulse_meter: RTL
======================

# acker_pulse_meter

Measures the width of high pulses on an asynchronous input and reports the width in clock cycles to a consumer through a valid/ack handshake. It is the measuring counterpart to the Ackerchip delay timer: the timer turns a count into a wait, and this block turns an observed interval back into a count. It sits between a raw external signal, such as a sensor or button line, and the Ackerchip control logic.

## Interface
- COUNT_WIDTH, 26: width of the cycle counter and of `result`.
- DEBOUNCE_CYCLES, 4: stability filter length. Used only when the debounce feature is compiled in. Legal range is 1..255.

- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low.
- sig_in  input  1  asynchronous signal to measure.
- ack  input  1  consumer acknowledges `result`; sampled as a level.
- result  output  COUNT_WIDTH  measured high width in cycles; registered.
- overflow  output  1  pulse exceeded the counter range; registered and qualified by `valid`.
- valid  output  1  `result` and `overflow` are valid and stable.
- busy  output  1  a pulse is currently being measured.

## Operation
- `sig_in` always passes through a 2-flop synchronizer. The second stage (optionally debounced) is the internal signal `s`.
- FSM states: WAIT_LOW, ARMED, MEASURE, HOLD.
  - WAIT_LOW: if `s`=0, go to ARMED.
  - ARMED: if `s`=1, go to MEASURE and load the counter with 1, so the first high cycle is counted.
  - MEASURE: while `s`=1, counter+1.
    - At all-ones the counter saturates and an internal overflow flag is set.
    - On `s`=0: `result`<=counter, `overflow`<=flag, `valid`<=1, go to HOLD.
  - HOLD: `result` and `overflow` are frozen.
    - `ack`=1: `valid`<=0, clear the flag, go to WAIT_LOW.
    - Any pulse that starts during HOLD, or is still high at ack, is discarded because the FSM must see `s`=0 in WAIT_LOW first.
- `busy` = (state == MEASURE), registered.
- `ack` is ignored outside HOLD.
- Arithmetic: unsigned, COUNT_WIDTH bits, no wrap-around.
  - A pulse of N synchronized cycles gives `result`=N for N ≤ 2^COUNT_WIDTH−1.
  - Longer pulses give all-ones with `overflow`=1.
- A pulse that is high when coming out of reset is never measured, because the FSM starts in WAIT_LOW.

## Timing
- Reset values:
  - state = WAIT_LOW
  - counter, `result` = 0
  - `overflow`, `valid`, `busy` = 0
  - synchronizer flops = 0
  - debounce state = 0
- Reset mid-operation aborts any measurement or pending result immediately, with no output of a partial result.
- Latency (macro off):
  - `busy` rises 3 edges after the first edge sampling `sig_in`=1 (2 synchronizer + 1 FSM).
  - `valid` rises 3 edges after the first edge sampling `sig_in`=0.
- The measured width equals the number of rising edges at which `sig_in` was sampled high. Minimum measurable width is 1 cycle (`result`=1).
- Handshake:
  - `valid` stays high until the edge after `ack` is sampled high in HOLD.
  - `valid`=0 the following cycle.
  - The earliest next `valid` is 3 cycles later, and only after a low then a full new pulse.
- `ack` held permanently high: each result is valid for exactly 1 cycle.

## Configuration
- Macro: `ACKER_PULSE_METER_DEBOUNCE_EN`.
- Defined:
  - `s` changes only after the synchronizer output has differed from `s` for DEBOUNCE_CYCLES consecutive cycles.
  - Excursions shorter than that are suppressed.
  - Both edges are delayed by DEBOUNCE_CYCLES, so the reported width of accepted pulses is unchanged and latencies grow by DEBOUNCE_CYCLES.
- Undefined: `s` = synchronizer output; DEBOUNCE_CYCLES is unused; no filter logic is generated.

## Test plan
- Reset with `sig_in`=1, held high for 10 cycles then low: no `valid`, `busy` stays 0.
- `sig_in` low, then a 5-cycle high pulse: `valid`=1 with `result`=5 and `overflow`=0, 3 cycles after the fall. `ack` for 1 cycle gives `valid`=0 on the next cycle.
- Pulse widths 1 and 2: `result`=1 and 2. With COUNT_WIDTH=4, a 20-cycle pulse gives `result`=15 and `overflow`=1; the next 3-cycle pulse gives `overflow`=0.
- No ack, and a second pulse of 7 during HOLD: `result` stays at its first value. Ack asserted while the second pulse is still high: that pulse is discarded, and a following 9-cycle pulse gives `result`=9.
- Reset asserted in MEASURE and in HOLD: next cycle all outputs are 0. A following 6-cycle pulse gives `result`=6.
- With the macro defined and DEBOUNCE_CYCLES=4:
  - A 2-cycle glitch gives no `busy` and no `valid`.
  - A 10-cycle pulse gives `result`=10, with `valid` rising 7 cycles after the fall.

Source files
------------

// File: rtl/acker_pulse_meter.sv
// acker_pulse_meter
//   Measures the width, in clock cycles, of high pulses on an asynchronous
//   input and hands the count to a consumer through a valid/ack handshake.
//
//   Optional feature: define ACKER_PULSE_METER_DEBOUNCE_EN to insert a
//   DEBOUNCE_CYCLES-long stability filter after the synchronizer.
//
//   Parameters
//     COUNT_WIDTH      width of the cycle counter and of result
//     DEBOUNCE_CYCLES  filter length (1..255), used only with the macro
//
//   Ports
//     clock     in   system clock, rising edge
//     reset     in   synchronous, active-low
//     sig_in    in   asynchronous signal to measure
//     ack       in   consumer acknowledge (level, only honoured in HOLD)
//     result    out  measured high width in cycles (registered)
//     overflow  out  pulse exceeded counter range (registered, with valid)
//     valid     out  result/overflow valid and stable
//     busy      out  a pulse is being measured (registered)
module acker_pulse_meter #(
  parameter int unsigned COUNT_WIDTH     = 26,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   sig_in,
  input  logic                   ack,
  output logic [COUNT_WIDTH-1:0] result,
  output logic                   overflow,
  output logic                   valid,
  output logic                   busy
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
    $error("acker_pulse_meter: DEBOUNCE_CYCLES must be 1..255");
  end

  typedef enum logic [1:0] {
    WAIT_LOW,
    ARMED,
    MEASURE,
    HOLD
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

  state_t                   state;
  logic                     sync1;
  logic                     sync2;
  logic                     live1;
  logic                     live2;
  logic                     s;
  logic                     idle_low;
  logic [COUNT_WIDTH-1:0]   count;
  logic                     ovf_flag;

  // Two-flop synchronizer. live1/live2 travel alongside the data and mark
  // stages that hold a real post-reset sample rather than the reset zero.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      live1 <= 1'b0;
      live2 <= 1'b0;
    end else begin
      sync1 <= sig_in;
      sync2 <= sync1;
      live1 <= 1'b1;
      live2 <= live1;
    end
  end

`ifdef ACKER_PULSE_METER_DEBOUNCE_EN
  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [7:0] db_count;
  logic       s_db;

  // s follows sync2 only after they have disagreed for DEBOUNCE_CYCLES
  // consecutive cycles; any agreement restarts the run.
  always_ff @(posedge clock) begin
    if (!reset) begin
      s_db     <= 1'b0;
      db_count <= '0;
    end else if (sync2 != s_db) begin
      if (db_count == DB_LAST) begin
        s_db     <= sync2;
        db_count <= '0;
      end else begin
        db_count <= db_count + 8'd1;
      end
    end else begin
      db_count <= '0;
    end
  end

  assign s = s_db;
`else
  assign s = sync2;
`endif

  // Arming needs a genuine low. The reset-zeroed synchronizer would
  // otherwise look like a low and let a pulse already high at reset
  // release be measured; requiring sync2 low as well keeps the debounced
  // s from arming while a rise is still pending in the filter.
  assign idle_low = live2 && !sync2 && !s;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= WAIT_LOW;
      count    <= '0;
      ovf_flag <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        WAIT_LOW: begin
          if (idle_low) state <= ARMED;
        end
        ARMED: begin
          if (s) begin
            state <= MEASURE;
            count <= ONE;
            busy  <= 1'b1;
          end
        end
        MEASURE: begin
          if (s) begin
            if (count == '1) ovf_flag <= 1'b1;
            else             count    <= count + ONE;
          end else begin
            result   <= count;
            overflow <= ovf_flag;
            valid    <= 1'b1;
            busy     <= 1'b0;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (ack) begin
            valid    <= 1'b0;
            overflow <= 1'b0;
            ovf_flag <= 1'b0;
            state    <= WAIT_LOW;
          end
        end
        default: state <= WAIT_LOW;
      endcase
    end
  end

endmodule
